// File: rtl/popcount_pattern_gen.sv
// Enumerates every WIDTH-bit value with exactly k set bits, ascending, over a valid/ready stream.
// Optional POPGEN_GOSPER_EN replaces the linear candidate scan with Gosper's next-combination step.
//
// state  | meaning
// S_IDLE | waiting for start; k latched on acceptance
// S_SCAN | linear: test one candidate per cycle; Gosper: one-cycle issue gap before the next beat
// S_EMIT | out_valid held with out_data until out_ready
// S_DONE | enumeration finished; leaves once start drops
module popcount_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    count_k,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   num_emitted
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] candidate;

`ifdef POPGEN_GOSPER_EN
    localparam int CTZW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   g_x, g_c, g_r;
    logic [WIDTH-1:0] g_next, first_pat;
    logic [CTZW-1:0]  g_ctz;
    logic             g_last;

    // Division by the lowest set bit becomes a shift by its index.
    always_comb begin
        g_x   = {1'b0, candidate};
        g_c   = g_x & (~g_x + 1'b1);
        g_r   = g_x + g_c;
        g_ctz = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (candidate[i]) g_ctz = CTZW'(i);
        g_next = WIDTH'((((g_r ^ g_x) >> 2) >> g_ctz) | g_r);
        g_last = (candidate == '0) || g_r[WIDTH];
        first_pat = '0;
        for (int i = 0; i < WIDTH; i++)
            first_pat[i] = (CW'(i) < count_k);
    end
`else
    logic [CW-1:0] k_reg;
    logic [CW-1:0] cand_ones;

    always_comb begin
        cand_ones = '0;
        for (int i = 0; i < WIDTH; i++)
            cand_ones = cand_ones + CW'(candidate[i]);
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            candidate   <= '0;
`ifndef POPGEN_GOSPER_EN
            k_reg       <= '0;
`endif
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            num_emitted <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_emitted <= '0;
                        done        <= 1'b0;
`ifdef POPGEN_GOSPER_EN
                        if (count_k > CW'(WIDTH)) begin
                            candidate <= '0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            candidate <= first_pat;
                            out_data  <= first_pat;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_EMIT;
                        end
`else
                        k_reg     <= count_k;
                        candidate <= '0;
                        busy      <= 1'b1;
                        state     <= S_SCAN;
`endif
                    end
                end
                S_SCAN: begin
`ifdef POPGEN_GOSPER_EN
                    out_data  <= candidate;
                    out_valid <= 1'b1;
                    state     <= S_EMIT;
`else
                    if (cand_ones == k_reg) begin
                        out_data  <= candidate;
                        out_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else if (candidate == '1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        candidate <= candidate + 1'b1;
                    end
`endif
                end
                S_EMIT: begin
                    if (out_ready) begin
                        num_emitted <= num_emitted + 1'b1;
                        out_valid   <= 1'b0;
`ifdef POPGEN_GOSPER_EN
                        if (g_last) begin
`else
                        if (candidate == '1) begin
`endif
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
`ifdef POPGEN_GOSPER_EN
                            candidate <= g_next;
`else
                            candidate <= candidate + 1'b1;
`endif
                            state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Directed bench for popcount_pattern_gen: a reference enumeration is queued per run and
// popped on every accepted beat; works unchanged with or without POPGEN_GOSPER_EN.
module tb_popcount_pattern_gen;

    localparam int WIDTH  = 8;
    localparam int CW     = 4;
    localparam int BUDGET = 3000;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [CW-1:0]    count_k;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   num_emitted;

    int n_pass  = 0;
    int n_total = 0;

    logic [WIDTH-1:0] sb[$];

    popcount_pattern_gen #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .count_k     (count_k),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .num_emitted (num_emitted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Runs one enumeration for k; stop_after>0 abandons it (start left high) after that many beats.
    task automatic run_k(input int k, input bit rnd, input int stop_after, input string tag);
        int               beats = 0;
        int               cyc   = 0;
        int               n_exp;
        bit               prev_stall = 1'b0;
        logic [WIDTH-1:0] prev_data = '0;
        logic [WIDTH-1:0] exp_v;
        logic [31:0]      vv;

        sb.delete();
        for (int v = 0; v < (1 << WIDTH); v++) begin
            vv = v;
            if ($countones(vv[WIDTH-1:0]) == k) sb.push_back(vv[WIDTH-1:0]);
        end
        n_exp = sb.size();

        @(negedge clock);
        start   = 1'b1;
        count_k = CW'(k);
        out_ready = 1'b0;
        @(negedge clock);
        count_k = ~count_k;
        while (!done && cyc < BUDGET) begin
            if (prev_stall) check({tag, "_stable"}, {24'd0, out_data}, {24'd0, prev_data});
            out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                check({tag, "_no_extra_beat"}, 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_v = sb.pop_front();
                    check({tag, "_beat"}, {24'd0, out_data}, {24'd0, exp_v});
                end
                beats++;
                if (stop_after != 0 && beats == stop_after) begin
                    @(posedge clock);
                    #1 out_ready = 1'b0;
                    return;
                end
            end
            cyc++;
            @(negedge clock);
        end
        out_ready = 1'b0;
        check({tag, "_done"},        32'(done), 32'd1);
        check({tag, "_busy_low"},    32'(busy), 32'd0);
        check({tag, "_valid_low"},   32'(out_valid), 32'd0);
        check({tag, "_num_emitted"}, 32'(num_emitted), 32'(n_exp));
        check({tag, "_beats"},       32'(beats), 32'(n_exp));
        check({tag, "_sb_empty"},    32'(sb.size()), 32'd0);
        @(negedge clock);
        check({tag, "_done_held"},   32'(done), 32'd1);
        check({tag, "_num_held"},    32'(num_emitted), 32'(n_exp));
        start = 1'b0;
        @(negedge clock);
        check({tag, "_done_clear"},  32'(done), 32'd0);
        check({tag, "_idle_busy"},   32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        count_k   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_data",  {24'd0, out_data}, 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_num",   32'(num_emitted), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        run_k(0, 1'b0, 0, "k0");
        run_k(8, 1'b0, 0, "k8");
        run_k(2, 1'b0, 0, "k2");
        run_k(4, 1'b1, 0, "k4_rand");
        run_k(9, 1'b0, 0, "k9");

        run_k(3, 1'b0, 5, "k3_abort");
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_data",  {24'd0, out_data}, 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy",  32'(busy), 32'd0);
        check("midrst_done",  32'(done), 32'd0);
        check("midrst_num",   32'(num_emitted), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_idle_after", 32'(busy), 32'd0);

        run_k(1, 1'b1, 0, "k1_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
